alu_seq: RTL

Parametrised, multi-cycle sequential ALU, successor to the single-cycle combinational ALU in the `tt_um_mialu` tile. It adds a valid/ready handshake on both sides and configurable operand width. It also adds iterative multiply and divide and a registered flag word. It sits between the tile's input-capture logic and the output mux, and it can be instantiated standalone in the cocotb bench.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_seq_muldiv.sv | 61 ++++++
 rtl/alu_seq.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, state and flag definitions for the sequential ALU.
package alu_pkg;

   localparam int unsigned OP_W   = 4;
   localparam int unsigned FLAG_W = 4;

   localparam int unsigned FLAG_Z  = 0;
   localparam int unsigned FLAG_C  = 1;
   localparam int unsigned FLAG_V  = 2;
   localparam int unsigned FLAG_DZ = 3;

   typedef enum logic [3:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_AND = 4'd2,
      OP_OR  = 4'd3,
      OP_XOR = 4'd4,
      OP_SHL = 4'd5,
      OP_SHR = 4'd6,
      OP_SRA = 4'd7,
      OP_MUL = 4'd8,
      OP_DIV = 4'd9
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Ops that need the multi-cycle datapath; DIV by zero resolves in one cycle.
   function automatic logic is_iterative(input logic [OP_W-1:0] op, input logic b_zero);
      return (op == OP_MUL) || ((op == OP_DIV) && !b_zero);
   endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative unsigned shift-add multiplier and restoring divider, one step per cycle.
module alu_seq_muldiv
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi,
   output logic             done
);

   localparam int unsigned CW = $clog2(WIDTH);

   logic [WIDTH-1:0] m;
   logic             div_q;
   logic [CW-1:0]    cnt;

   // One iteration: MUL shifts {hi,lo} right with conditional add, DIV shifts left with trial subtract.
   function automatic logic [2*WIDTH-1:0] step(input logic is_div, input logic [WIDTH-1:0] h,
                                               input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] d);
      logic [WIDTH:0] acc;
      if (is_div) begin
         acc = {h, l[WIDTH-1]};
         if (acc >= {1'b0, d}) begin
            acc = acc - {1'b0, d};
            return {acc[WIDTH-1:0], l[WIDTH-2:0], 1'b1};
         end
         return {acc[WIDTH-1:0], l[WIDTH-2:0], 1'b0};
      end
      acc = {1'b0, h} + {1'b0, (l[0] ? d : {WIDTH{1'b0}})};
      return {acc[WIDTH:1], acc[0], l[WIDTH-1:1]};
   endfunction

   assign done = (cnt == '0);

   // The first step is taken on the start edge, so the counter holds the steps still to run.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lo    <= '0;
         hi    <= '0;
         m     <= '0;
         div_q <= 1'b0;
         cnt   <= '0;
      end else if (start) begin
         {hi, lo} <= step(op == OP_DIV, '0, a, b);
         m        <= b;
         div_q    <= (op == OP_DIV);
         cnt      <= CW'(WIDTH - 1);
      end else if (cnt != '0) begin
         {hi, lo} <= step(div_q, hi, lo, m);
         cnt      <= cnt - CW'(1);
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshakes on request and result, plus registered flags.
module alu_seq
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   op,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  result,
   output logic [WIDTH-1:0]  result_hi,
   output logic [FLAG_W-1:0] flags
);

   localparam int unsigned SW = $clog2(WIDTH);

   state_e             state;
   logic               accept;
   logic               b_zero;
   logic               iterative;
   logic               calc_mul;
   logic [SW-1:0]      shamt;
   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     diff;
   logic [WIDTH-1:0]   alu_res;
   logic [WIDTH-1:0]   alu_hi;
   logic [FLAG_W-1:0]  alu_flags;
   logic [WIDTH-1:0]   md_lo;
   logic [WIDTH-1:0]   md_hi;
   logic               md_done;
   logic [FLAG_W-1:0]  md_flags;

   // A finished result frees the slot on the same edge it is taken, giving back-to-back issue.
   assign in_ready  = !rst && ((state == ST_IDLE) || ((state == ST_DONE) && out_ready));
   assign accept    = in_valid && in_ready;
   assign b_zero    = (b == '0);
   assign iterative = is_iterative(op, b_zero);
   assign shamt     = b[SW-1:0];
   assign sum       = {1'b0, a} + {1'b0, b};
   assign diff      = {1'b0, a} - {1'b0, b};

   alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk   (clk),
      .rst   (rst),
      .start (accept && iterative),
      .op    (op),
      .a     (a),
      .b     (b),
      .lo    (md_lo),
      .hi    (md_hi),
      .done  (md_done)
   );

   // Single-cycle datapath, including the divide-by-zero and reserved-op outcomes.
   always_comb begin
      alu_res   = '0;
      alu_hi    = '0;
      alu_flags = '0;
      case (op)
         OP_ADD: begin
            alu_res           = sum[WIDTH-1:0];
            alu_flags[FLAG_C] = sum[WIDTH];
            alu_flags[FLAG_V] = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res           = diff[WIDTH-1:0];
            alu_flags[FLAG_C] = diff[WIDTH];
            alu_flags[FLAG_V] = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND: alu_res = a & b;
         OP_OR:  alu_res = a | b;
         OP_XOR: alu_res = a ^ b;
         OP_SHL: alu_res = a << shamt;
         OP_SHR: alu_res = a >> shamt;
         OP_SRA: alu_res = WIDTH'($signed(a) >>> shamt);
         OP_DIV: begin
            alu_res            = '1;
            alu_hi             = a;
            alu_flags[FLAG_DZ] = 1'b1;
         end
         default: ;
      endcase
      alu_flags[FLAG_Z] = (alu_res == '0) && (op <= OP_DIV);
   end

   always_comb begin
      md_flags         = '0;
      md_flags[FLAG_Z] = (md_lo == '0);
      md_flags[FLAG_V] = calc_mul && (md_hi != '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         out_valid <= 1'b0;
         result    <= '0;
         result_hi <= '0;
         flags     <= '0;
         calc_mul  <= 1'b0;
      end else begin
         case (state)
            ST_CALC: begin
               if (md_done) begin
                  state     <= ST_DONE;
                  out_valid <= 1'b1;
                  result    <= md_lo;
                  result_hi <= md_hi;
                  flags     <= md_flags;
               end
            end
            default: begin
               if (out_valid && out_ready) begin
                  state     <= ST_IDLE;
                  out_valid <= 1'b0;
               end
               if (accept) begin
                  calc_mul <= (op == OP_MUL);
                  if (iterative) begin
                     state     <= ST_CALC;
                     out_valid <= 1'b0;
                  end else begin
                     state     <= ST_DONE;
                     out_valid <= 1'b1;
                     result    <= alu_res;
                     result_hi <= alu_hi;
                     flags     <= alu_flags;
                  end
               end
            end
         endcase
      end
   end

endmodule
